// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - pipeline stall/flush sequencer with cause register, perf counters and watchdog
// One cause wins per cycle (DWAIT > LOADUSE > BRANCH > IWAIT); control outputs are combinational.
module pipe_hazard_ctrl #(
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [4:0]       ID_Rs,
  input  logic [4:0]       ID_Rt,
  input  logic             ID_UsesRt,
  input  logic             EX_MemRead,
  input  logic [4:0]       EX_Rd,
  input  logic             ID_BranchTaken,
  input  logic             IMEM_Ready,
  input  logic             DMEM_Req,
  input  logic             DMEM_Ready,
  output logic             STALL_PC,
  output logic             STALL_IFID,
  output logic             FLUSH_IFID,
  output logic             BUBBLE_IDEX,
  output logic             STALL_BACK,
  output logic [1:0]       CAUSE,
  output logic [CNT_W-1:0] STALL_CYCLES,
  output logic [CNT_W-1:0] FLUSH_COUNT,
  output logic             TIMEOUT_ERR
);

  typedef enum logic [1:0] {
    C_RUN     = 2'd0,
    C_LOADUSE = 2'd1,
    C_DWAIT   = 2'd2,
    C_IWAIT   = 2'd3
  } cause_t;

  localparam int RUN_W = $clog2(TIMEOUT) + 1;
  localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(TIMEOUT - 1);

  cause_t           cause_q, cause_d;
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
  logic [CNT_W-1:0] flush_count_q, flush_count_d;
  logic [RUN_W-1:0] run_q, run_d;
  logic             timeout_err_q, timeout_err_d;

  logic dwait, loaduse, branch_win;

  assign dwait   = DMEM_Req && !DMEM_Ready;
  assign loaduse = EX_MemRead && (EX_Rd != 5'd0) &&
                   ((EX_Rd == ID_Rs) || (ID_UsesRt && (EX_Rd == ID_Rt)));

  always_comb begin
    STALL_PC    = 1'b0;
    STALL_IFID  = 1'b0;
    FLUSH_IFID  = 1'b0;
    BUBBLE_IDEX = 1'b0;
    STALL_BACK  = 1'b0;
    cause_d     = C_RUN;
    branch_win  = 1'b0;
    if (RESET) begin
      // Fill IF/ID and ID/EX with NOPs while held in reset.
      FLUSH_IFID  = 1'b1;
      BUBBLE_IDEX = 1'b1;
    end else if (dwait) begin
      STALL_PC   = 1'b1;
      STALL_IFID = 1'b1;
      STALL_BACK = 1'b1;
      cause_d    = C_DWAIT;
    end else if (loaduse) begin
      STALL_PC    = 1'b1;
      STALL_IFID  = 1'b1;
      BUBBLE_IDEX = 1'b1;
      cause_d     = C_LOADUSE;
    end else if (ID_BranchTaken) begin
      FLUSH_IFID = 1'b1;
      branch_win = 1'b1;
    end else if (!IMEM_Ready) begin
      STALL_PC   = 1'b1;
      FLUSH_IFID = 1'b1;
      cause_d    = C_IWAIT;
    end
  end

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    flush_count_d  = flush_count_q;
    run_d          = '0;
    timeout_err_d  = timeout_err_q;
    if (STALL_PC && (stall_cycles_q != '1)) stall_cycles_d = stall_cycles_q + CNT_W'(1);
    if (branch_win && (flush_count_q != '1)) flush_count_d = flush_count_q + CNT_W'(1);
    if (STALL_PC) begin
      run_d = (run_q == '1) ? run_q : run_q + RUN_W'(1);
      if (run_q == RUN_LAST) timeout_err_d = 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      cause_q        <= C_RUN;
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
      run_q          <= '0;
      timeout_err_q  <= 1'b0;
    end else begin
      cause_q        <= cause_d;
      stall_cycles_q <= stall_cycles_d;
      flush_count_q  <= flush_count_d;
      run_q          <= run_d;
      timeout_err_q  <= timeout_err_d;
    end
  end

  assign CAUSE        = cause_q;
  assign STALL_CYCLES = stall_cycles_q;
  assign FLUSH_COUNT  = flush_count_q;
  assign TIMEOUT_ERR  = timeout_err_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - directed and random checks of pipe_hazard_ctrl against a behavioural model
module tb_pipe_hazard_ctrl;
  localparam int CNT_W   = 4;
  localparam int TIMEOUT = 8;
  localparam int CMAX    = (1 << CNT_W) - 1;

  logic       CLK = 1'b0;
  logic       RESET;
  logic [4:0] ID_Rs, ID_Rt, EX_Rd;
  logic       ID_UsesRt, EX_MemRead, ID_BranchTaken, IMEM_Ready, DMEM_Req, DMEM_Ready;
  logic       STALL_PC, STALL_IFID, FLUSH_IFID, BUBBLE_IDEX, STALL_BACK, TIMEOUT_ERR;
  logic [1:0] CAUSE;
  logic [CNT_W-1:0] STALL_CYCLES, FLUSH_COUNT;

  int n_cmp = 0;
  int n_bad = 0;

  // Model state: plain integers, saturation applied arithmetically.
  int m_cause, m_stalls, m_flushes, m_consec;
  bit m_err;

  pipe_hazard_ctrl #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .CLK(CLK), .RESET(RESET),
    .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_UsesRt(ID_UsesRt),
    .EX_MemRead(EX_MemRead), .EX_Rd(EX_Rd), .ID_BranchTaken(ID_BranchTaken),
    .IMEM_Ready(IMEM_Ready), .DMEM_Req(DMEM_Req), .DMEM_Ready(DMEM_Ready),
    .STALL_PC(STALL_PC), .STALL_IFID(STALL_IFID), .FLUSH_IFID(FLUSH_IFID),
    .BUBBLE_IDEX(BUBBLE_IDEX), .STALL_BACK(STALL_BACK), .CAUSE(CAUSE),
    .STALL_CYCLES(STALL_CYCLES), .FLUSH_COUNT(FLUSH_COUNT), .TIMEOUT_ERR(TIMEOUT_ERR)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected control word from the cause rules: {pc, ifid, flush, bubble, back}, plus cause code and branch flag.
  task automatic ref_ctrl(output logic [4:0] ctl, output int cause, output bit br);
    bit dw, lu;
    dw = DMEM_Req && !DMEM_Ready;
    lu = EX_MemRead && EX_Rd != 0 && (EX_Rd == ID_Rs || (ID_UsesRt && EX_Rd == ID_Rt));
    br = 0;
    cause = 0;
    if (RESET)                 ctl = 5'b00110;
    else if (dw)             begin ctl = 5'b11001; cause = 2; end
    else if (lu)             begin ctl = 5'b11010; cause = 1; end
    else if (ID_BranchTaken) begin ctl = 5'b00100; br = 1; end
    else if (!IMEM_Ready)    begin ctl = 5'b10100; cause = 3; end
    else                       ctl = 5'b00000;
  endtask

  task automatic chk_regs(input string when);
    chk({"cause_", when}, CAUSE, m_cause);
    chk({"stall_cycles_", when}, STALL_CYCLES, m_stalls);
    chk({"flush_count_", when}, FLUSH_COUNT, m_flushes);
    chk({"timeout_err_", when}, TIMEOUT_ERR, m_err);
  endtask

  // Called at a negedge with inputs already driven; returns at the next negedge.
  task automatic step();
    logic [4:0] e;
    int c;
    bit br;
    #1;
    if (RESET) begin
      m_cause = 0; m_stalls = 0; m_flushes = 0; m_consec = 0; m_err = 0;
    end
    ref_ctrl(e, c, br);
    chk("stall_pc", STALL_PC, e[4]);
    chk("stall_ifid", STALL_IFID, e[3]);
    chk("flush_ifid", FLUSH_IFID, e[2]);
    chk("bubble_idex", BUBBLE_IDEX, e[1]);
    chk("stall_back", STALL_BACK, e[0]);
    chk_regs("pre");
    @(posedge CLK);
    if (!RESET) begin
      m_cause = c;
      if (e[4]) begin
        m_stalls = (m_stalls < CMAX) ? m_stalls + 1 : CMAX;
        m_consec++;
      end else m_consec = 0;
      if (br) m_flushes = (m_flushes < CMAX) ? m_flushes + 1 : CMAX;
      if (m_consec >= TIMEOUT) m_err = 1;
    end
    #1;
    chk_regs("post");
    @(negedge CLK);
  endtask

  task automatic idle_inputs();
    RESET = 0; ID_Rs = 0; ID_Rt = 0; ID_UsesRt = 0; EX_MemRead = 0; EX_Rd = 0;
    ID_BranchTaken = 0; IMEM_Ready = 1; DMEM_Req = 0; DMEM_Ready = 1;
  endtask

  task automatic do_reset(input int cycles);
    RESET = 1;
    for (int i = 0; i < cycles; i++) step();
    RESET = 0;
  endtask

  initial begin
    idle_inputs();
    RESET = 1;
    m_cause = 0; m_stalls = 0; m_flushes = 0; m_consec = 0; m_err = 0;
    @(negedge CLK);
    do_reset(2);
    step();

    // Load-use on rs, then the same with EX_Rd = 0.
    EX_MemRead = 1; EX_Rd = 8; ID_Rs = 8;
    step();
    chk("lu_cause", CAUSE, 1);
    chk("lu_stalls", STALL_CYCLES, 1);
    EX_Rd = 0; ID_Rs = 0;
    step();
    EX_MemRead = 1; EX_Rd = 9; ID_Rt = 9; ID_UsesRt = 1;
    step();
    idle_inputs();

    // DWAIT with a taken branch held in ID, then the ready cycle flushes.
    DMEM_Req = 1; DMEM_Ready = 0; ID_BranchTaken = 1;
    for (int i = 0; i < 3; i++) step();
    DMEM_Ready = 1;
    step();
    chk("dw_flushes", FLUSH_COUNT, 1);
    idle_inputs();

    // IWAIT, then IWAIT overridden by a branch.
    IMEM_Ready = 0;
    step(); step();
    chk("iw_cause", CAUSE, 3);
    ID_BranchTaken = 1;
    step();
    idle_inputs();

    // Mid-stall reset, then watchdog boundary.
    DMEM_Req = 1; DMEM_Ready = 0; IMEM_Ready = 0;
    step(); step();
    do_reset(2);
    DMEM_Req = 1; DMEM_Ready = 0;
    for (int i = 0; i < TIMEOUT - 1; i++) step();
    chk("wd_before", TIMEOUT_ERR, 0);
    step();
    chk("wd_at", TIMEOUT_ERR, 1);
    DMEM_Ready = 1;
    step(); step();
    chk("wd_sticky", TIMEOUT_ERR, 1);

    // Saturation of the stall counter.
    do_reset(1);
    DMEM_Req = 1; DMEM_Ready = 0;
    for (int i = 0; i < 20; i++) step();
    chk("sat_stalls", STALL_CYCLES, CMAX);
    idle_inputs();
    do_reset(1);

    // Random traffic with small register numbers so hazards are frequent.
    for (int i = 0; i < 600; i++) begin
      RESET          = ($urandom_range(0, 59) == 0);
      ID_Rs          = 5'($urandom_range(0, 3));
      ID_Rt          = 5'($urandom_range(0, 3));
      EX_Rd          = 5'($urandom_range(0, 3));
      ID_UsesRt      = 1'($urandom_range(0, 1));
      EX_MemRead     = ($urandom_range(0, 3) == 0);
      ID_BranchTaken = ($urandom_range(0, 4) == 0);
      IMEM_Ready     = ($urandom_range(0, 4) != 0);
      DMEM_Req       = ($urandom_range(0, 2) == 0);
      DMEM_Ready     = ($urandom_range(0, 4) == 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
